// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the pipelined ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  typedef enum logic {
    IDLE,
    DIV_BUSY
  } state_e;

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring divider, one quotient bit per cycle.
module alu_divider
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             done_q, done_d;

  // Returns {partial remainder, shifted quotient}; the low bits of the
  // quotient register hold dividend bits not yet consumed.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] d);
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] rn;
    logic             qb;
    sh = {r, q[WIDTH-1]};
    if (sh >= {1'b0, d}) begin
      rn = sh[WIDTH-1:0] - d;
      qb = 1'b1;
    end else begin
      rn = sh[WIDTH-1:0];
      qb = 1'b0;
    end
    return {rn, q[WIDTH-2:0], qb};
  endfunction

  // The first iteration runs on the start edge so the final bit lands
  // WIDTH-1 edges later, letting the top register the result one edge after.
  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    done_d = 1'b0;
    if (start) begin
      {rem_d, quo_d} = div_step('0, dividend, divisor);
      dvs_d          = divisor;
      cnt_d          = CW'(WIDTH - 1);
    end else if (cnt_q != '0) begin
      {rem_d, quo_d} = div_step(rem_q, quo_q, dvs_q);
      cnt_d          = cnt_q - CW'(1);
      done_d         = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      done_q <= done_d;
    end
  end

  assign busy      = (cnt_q != '0);
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_pipe.sv
// Parametrised ALU with valid/ready handshake, registered result and flags,
// and a multi-cycle divider for DIV.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             carry_out,
  output logic             zero,
  output logic             div_by_zero
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;

  logic             accept, is_div, div_start;
  logic             div_busy, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;

  assign in_ready  = !rst && (state_q == IDLE) && !div_busy && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_div    = (opcode == OP_DIV);
  assign div_start = accept && is_div && (B != '0);

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (A),
    .divisor   (B),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    sum     = {1'b0, A} + {1'b0, B};
    diff    = {1'b0, A} - {1'b0, B};
    prod    = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    alu_res = '0;
    alu_c   = 1'b0;
    case (opcode)
      OP_ADD: begin alu_res = sum[WIDTH-1:0];   alu_c = sum[WIDTH];       end
      OP_SUB: begin alu_res = diff[WIDTH-1:0];  alu_c = diff[WIDTH];      end
      OP_MUL: begin alu_res = prod[WIDTH-1:0];  alu_c = |prod[2*WIDTH-1:WIDTH]; end
      OP_DIV: alu_res = '1;
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_NOT: alu_res = ~A;
      OP_XOR: alu_res = A ^ B;
    endcase
  end

  // Output register holds unless a handshake drains it or a new result loads;
  // a load on the same edge as a handshake keeps out_valid high.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    rem_d       = rem_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    dbz_d       = dbz_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (div_start) begin
          state_d = DIV_BUSY;
        end else if (accept) begin
          out_valid_d = 1'b1;
          result_d    = alu_res;
          rem_d       = is_div ? A : '0;
          carry_d     = alu_c;
          zero_d      = (alu_res == '0);
          dbz_d       = is_div;
        end
      end
      DIV_BUSY: begin
        if (div_done) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          result_d    = div_quo;
          rem_d       = div_rem;
          carry_d     = 1'b0;
          zero_d      = (div_quo == '0);
          dbz_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      rem_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      rem_q       <= rem_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      dbz_q       <= dbz_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign remainder   = rem_q;
  assign carry_out   = carry_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed vector bench for alu_pipe at WIDTH=4 and WIDTH=8.
module tb_alu_pipe;

  typedef struct {
    bit         w4;
    logic [2:0] op;
    logic [7:0] a, b, res, rem;
    logic       c, z, dbz;
    int         lat, busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv4 = 0, ir4, ov4, ord4 = 1, c4, z4, d4;
  logic [3:0] a4 = '0, b4 = '0, r4, m4;
  logic [2:0] op4 = '0;
  logic       iv8 = 0, ir8, ov8, ord8 = 1, c8, z8, d8;
  logic [7:0] a8 = '0, b8 = '0, r8, m8;
  logic [2:0] op8 = '0;

  alu_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4), .opcode(op4),
    .out_valid(ov4), .out_ready(ord4), .result(r4), .remainder(m4), .carry_out(c4),
    .zero(z4), .div_by_zero(d4));

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8), .opcode(op8),
    .out_valid(ov8), .out_ready(ord8), .result(r8), .remainder(m8), .carry_out(c8),
    .zero(z8), .div_by_zero(d8));

  logic       sel4 = 0;
  logic       ir_m, ov_m, c_m, z_m, d_m;
  logic [7:0] r_m, m_m;
  assign ir_m = sel4 ? ir4 : ir8;
  assign ov_m = sel4 ? ov4 : ov8;
  assign c_m  = sel4 ? c4 : c8;
  assign z_m  = sel4 ? z4 : z8;
  assign d_m  = sel4 ? d4 : d8;
  assign r_m  = sel4 ? {4'b0, r4} : r8;
  assign m_m  = sel4 ? {4'b0, m4} : m8;

  int n_chk = 0;
  int n_pass = 0;
  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int w, lat, busy;
    sel4 = v.w4;
    if (v.w4) begin a4 = v.a[3:0]; b4 = v.b[3:0]; op4 = v.op; iv4 = 1; end
    else      begin a8 = v.a;      b8 = v.b;      op8 = v.op; iv8 = 1; end
    w = 0;
    while (!ir_m && w < 50) begin tick(); w++; end
    chk({tag, ".in_ready"}, ir_m, 1);
    tick();
    iv4 = 0; iv8 = 0;
    lat = 1; busy = 0;
    while (!ov_m && lat < 50) begin
      if (!ir_m) busy++;
      tick();
      lat++;
    end
    chk({tag, ".latency"}, lat, v.lat);
    chk({tag, ".busy"}, busy, v.busy);
    chk({tag, ".result"}, r_m, v.res);
    chk({tag, ".remainder"}, m_m, v.rem);
    chk({tag, ".carry"}, c_m, v.c);
    chk({tag, ".zero"}, z_m, v.z);
    chk({tag, ".dbz"}, d_m, v.dbz);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    //          w4 op      a      b      res    rem    c  z  dbz lat busy
    vecs[0]  = '{1, 3'b000, 8'd3,  8'd5,  8'd8,  8'd0,  0, 0, 0, 1, 0};
    vecs[1]  = '{1, 3'b001, 8'd9,  8'd3,  8'd6,  8'd0,  0, 0, 0, 1, 0};
    vecs[2]  = '{1, 3'b010, 8'd2,  8'd3,  8'd6,  8'd0,  0, 0, 0, 1, 0};
    vecs[3]  = '{1, 3'b011, 8'd8,  8'd2,  8'd4,  8'd0,  0, 0, 0, 5, 4};
    vecs[4]  = '{1, 3'b100, 8'hA,  8'hC,  8'h8,  8'd0,  0, 0, 0, 1, 0};
    vecs[5]  = '{1, 3'b101, 8'hA,  8'h5,  8'hF,  8'd0,  0, 0, 0, 1, 0};
    vecs[6]  = '{1, 3'b110, 8'hA,  8'h3,  8'h5,  8'd0,  0, 0, 0, 1, 0};
    vecs[7]  = '{0, 3'b000, 8'd200, 8'd100, 8'd44, 8'd0, 1, 0, 0, 1, 0};
    vecs[8]  = '{0, 3'b001, 8'd3,  8'd9,  8'd250, 8'd0, 1, 0, 0, 1, 0};
    vecs[9]  = '{0, 3'b010, 8'd20, 8'd13, 8'd4,  8'd0,  1, 0, 0, 1, 0};
    vecs[10] = '{0, 3'b111, 8'hAA, 8'hAA, 8'h00, 8'd0,  0, 1, 0, 1, 0};
    vecs[11] = '{0, 3'b011, 8'd200, 8'd7, 8'd28, 8'd4,  0, 0, 0, 9, 8};
    vecs[12] = '{0, 3'b011, 8'd55, 8'd0,  8'd255, 8'd55, 0, 0, 1, 1, 0};
    vecs[13] = '{0, 3'b011, 8'd5,  8'd9,  8'd0,  8'd5,  0, 1, 0, 9, 8};

    // Reset state
    tick(); tick();
    chk("rst.ov8", ov8, 0);   chk("rst.res8", r8, 0);  chk("rst.rem8", m8, 0);
    chk("rst.c8", c8, 0);     chk("rst.z8", z8, 0);    chk("rst.dbz8", d8, 0);
    chk("rst.ir8", ir8, 0);   chk("rst.ov4", ov4, 0);  chk("rst.ir4", ir4, 0);
    rst = 0;
    #1;
    chk("rst.ir8_after", ir8, 1);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: ADD held, pending AND waits for the handshake
    sel4 = 0;
    tick();
    ord8 = 0;
    a8 = 8'd1; b8 = 8'd1; op8 = 3'b000; iv8 = 1;
    tick();
    chk("bp.ov", ov8, 1);
    chk("bp.res", r8, 2);
    a8 = 8'hF0; b8 = 8'h3C; op8 = 3'b100;
    for (int k = 0; k < 3; k++) begin
      chk("bp.ir_low", ir8, 0);
      tick();
      chk("bp.hold_ov", ov8, 1);
      chk("bp.hold_res", r8, 2);
      chk("bp.hold_c", c8, 0);
    end
    ord8 = 1;
    #1;
    chk("bp.ir_release", ir8, 1);
    tick();
    iv8 = 0;
    chk("bp.and_ov", ov8, 1);
    chk("bp.and_res", r8, 8'h30);
    tick();
    chk("bp.drain_ov", ov8, 0);

    // Reset during DIV 255/1
    a8 = 8'd255; b8 = 8'd1; op8 = 3'b011; iv8 = 1;
    #1;
    chk("rd.ir", ir8, 1);
    tick();
    iv8 = 0;
    chk("rd.busy1", ir8, 0);
    tick(); tick();
    rst = 1;
    tick();
    chk("rd.ov", ov8, 0);   chk("rd.res", r8, 0);  chk("rd.rem", m8, 0);
    chk("rd.c", c8, 0);     chk("rd.z", z8, 0);    chk("rd.dbz", d8, 0);
    chk("rd.ir_in_rst", ir8, 0);
    rst = 0;
    #1;
    chk("rd.ir_after", ir8, 1);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ov8) seen++;
    end
    chk("rd.no_ov_pulse", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
